// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and clear sequencer for a single-port RAM
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req0/1, we0/1            level request held until ack; 1 = write, 0 = read
//   addr0/1, wdata0/1        access address and write data per port
//   ack0/1                   one-cycle completion pulse per port
//   rdata0/1                 read data, valid from ack, held until the next read ack
//   clr_start                starts a fill sweep of every location (honoured in IDLE only)
//   clr_done                 one-cycle pulse after the last sweep write
//   busy                     high in every state except IDLE
//   ram_addr, ram_din, ram_wr  registered RAM controls
//   ram_dout                 combinational RAM read data for ram_addr

module ram_arbiter #(
    parameter int               AW   = 11,
    parameter int               DW   = 8,
    parameter logic [DW-1:0]    FILL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    input  logic          clr_start,
    output logic          clr_done,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    state_t state;

    // last_grant doubles as the port currently being served in ACCESS/ACK.
    logic last_grant;
    logic pick;

    // A lone request wins outright; on a tie the port not served last wins.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_wr     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            clr_done   <= 1'b0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            clr_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        ram_addr <= '0;
                        ram_din  <= FILL;
                        ram_wr   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end else if (req0 || req1) begin
                        ram_addr   <= pick ? addr1  : addr0;
                        ram_din    <= pick ? wdata1 : wdata0;
                        ram_wr     <= pick ? we1    : we0;
                        last_grant <= pick;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ram_wr still holds the granted request's we here.
                    if (!ram_wr) begin
                        if (last_grant) rdata1 <= ram_dout;
                        else            rdata0 <= ram_dout;
                    end
                    if (last_grant) ack1 <= 1'b1;
                    else            ack0 <= 1'b1;
                    ram_wr <= 1'b0;
                    state  <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                CLEAR: begin
                    // Stop on the last address rather than wrapping to 0.
                    if (ram_addr != {AW{1'b1}}) begin
                        ram_addr <= ram_addr + AW'(1);
                    end else begin
                        ram_wr   <= 1'b0;
                        clr_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 2K×8 single-port cache RAM. It owns the RAM's address, write-data and write-enable inputs, and serialises one access at a time from two client ports using a req/ack handshake. It also provides a bulk-clear sweep that fills every RAM location with a constant. It sits between the cache-side clients and the RAM instance.

## Interface
- AW, 11, RAM address width (2048 locations)
- DW, 8, RAM data width
- FILL, 8'h00, value written to every location during a clear sweep

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, level, held until ack
- we0 / we1  in  1  1 = write, 0 = read (valid while req high)
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid from the ack cycle, held until the next ack on that port
- clr_start  in  1  start a clear sweep (pulse, sampled in IDLE only)
- clr_done  out  1  one-cycle pulse when the sweep completes
- busy  out  1  high in every state except IDLE
- ram_addr  out  AW  to RAM addr (registered)
- ram_din  out  DW  to RAM din (registered)
- ram_wr  out  1  to RAM wr (registered)
- ram_dout  in  DW  from RAM dout (combinational read of ram_addr)

## Operation
- States: IDLE, ACCESS, ACK, CLEAR.
- Reset values: state=IDLE, ram_addr=0, ram_din=0, ram_wr=0, ack0=ack1=0, rdata0=rdata1=0, clr_done=0, busy=0, last_grant=1 (port 0 wins the first tie).
- IDLE, priority at the sampling edge:
  - clr_start=1 → CLEAR with ram_addr=0, ram_din=FILL, ram_wr=1.
  - Else, if exactly one req is high → grant that port.
  - Else, if both are high → grant the port ≠ last_grant.
  - The grant registers ram_addr=addrN, ram_din=wdataN, ram_wr=weN, sets last_grant=N, and moves to ACCESS.
- ACCESS (1 cycle):
  - A write commits at the closing edge.
  - For a read, ram_dout is captured into rdataN at the closing edge. rdataN is unchanged on a write.
  - At the closing edge: ram_wr←0, ackN←1, state→ACK.
- ACK (1 cycle): ackN=1. All reqs are ignored. Closing edge: ackN←0, state→IDLE.
- Clients drop req on the edge where they see ack. A req still high in the following IDLE cycle is a new access.
- CLEAR:
  - One write per cycle, addresses 0..2^AW−1.
  - At each edge: if ram_addr ≠ 2^AW−1, ram_addr increments.
  - Otherwise: ram_wr←0, clr_done←1, state→IDLE. No wrap to 0; ram_addr holds 2^AW−1.
  - clr_done is cleared at the next edge.
- clr_start outside IDLE is ignored, not queued.
- Reqs during CLEAR wait and are arbitrated in IDLE afterwards.
- Async reset at any time forces the reset values immediately. ram_wr drops, so no write occurs at the next edge. A partial clear or access is abandoned with no ack and no clr_done.

## Timing
- Access latency: req sampled at edge E0 (IDLE).
  - ACCESS occupies cycle 1.
  - ack and rdata are visible in cycle 2 (ACK).
  - IDLE is in cycle 3.
- Throughput: at most one access per 3 cycles.
- Clear: ram_wr is high for exactly 2^AW consecutive cycles. clr_done is high in the first cycle after the last write (state IDLE).
- A request pending at clr_done is granted at that cycle's edge; its ack appears 2 cycles after the clr_done cycle.
- busy=1 in ACCESS, ACK and CLEAR; 0 in IDLE.

## Test plan
- Reset: hold rst_n=0 → all outputs 0, busy=0. Release with no req → ram_wr stays 0.
- Write then read:
  - req0 write addr 0x123 data 0xA5 → ram_wr=1 with ram_addr=0x123 for exactly one cycle; ack0 2 cycles after req.
  - Then req1 read 0x123 → ack1 with rdata1=0xA5; rdata0 unchanged.
- Tie-break from reset: req0 and req1 both raised in the same cycle, held until acked.
  - ack0 comes 2 cycles after the req cycle, ack1 5 cycles after.
  - A second simultaneous pair raised after both acks → port 0 is granted first again (last_grant=1).
- Clear:
  - Pulse clr_start → ram_wr high for 2048 cycles, ram_addr 0x000..0x7FF in order, then clr_done for 1 cycle.
  - req0 read 0x7FF raised mid-sweep → ack0 2 cycles after clr_done, rdata0=FILL.
- Clear ignored: clr_start pulsed during ACCESS → no CLEAR entered, clr_done never asserted.
- Reset mid-sweep at ram_addr=0x400:
  - ram_wr is 0 immediately and no clr_done appears.
  - A prior write of 0x5A to 0x500 reads back 0x5A; address 0x3FF reads FILL.
